// File: rtl/mem_arbiter_if.sv
// Generic single-beat memory request bus shared by both requesters and the mapper side.
// master drives the request; slave answers with ready and the read return stream.
interface mem_arbiter_if;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic        write_req;
  logic        read_req;
  logic [31:0] read_data;
  logic        read_data_valid;

  modport master (
    output addr, write_data, byte_enable, write_req, read_req,
    input  ready, read_data, read_data_valid
  );

  modport slave (
    input  addr, write_data, byte_enable, write_req, read_req,
    output ready, read_data, read_data_valid
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch (port 0) and data (port 1) in front of
// the mapper; an in-order tag FIFO routes each read return back to the port that issued it.
module mem_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  p0_io,
  mem_arbiter_if.slave  p1_io,
  mem_arbiter_if.master mem_io
);

  localparam int PTR_W   = $clog2(MAX_OUTSTANDING);
  localparam int COUNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic               lastGrant_q, lastGrant_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic               tag_q [MAX_OUTSTANDING];

  logic req0, req1;
  logic winnerIs1;
  logic full, notEmpty;
  logic ready0, ready1;
  logic accept0, accept1;
  logic push, pop, pushTag;
  logic headTag;

  assign req0     = p0_io.read_req | p0_io.write_req;
  assign req1     = p1_io.read_req | p1_io.write_req;
  assign full     = (count_q == COUNT_W'(MAX_OUTSTANDING));
  assign notEmpty = (count_q != '0);

  // Under contention the port that did not win last time goes next.
  always_comb begin
    winnerIs1 = 1'b0;
    if (req0 && req1) begin
      winnerIs1 = ~lastGrant_q;
    end else begin
      winnerIs1 = req1;
    end
  end

  // A full tag FIFO only blocks reads; a pop in the same cycle does not free a slot early.
  assign ready0 = mem_io.ready & (~winnerIs1 | ~req1) & ~(p0_io.read_req & full);
  assign ready1 = mem_io.ready & (winnerIs1 | ~req0) & ~(p1_io.read_req & full);

  assign accept0 = ready0 & req0;
  assign accept1 = ready1 & req1;

  assign p0_io.ready = ready0;
  assign p1_io.ready = ready1;

  always_comb begin
    mem_io.addr        = '0;
    mem_io.write_data  = '0;
    mem_io.byte_enable = '0;
    mem_io.write_req   = 1'b0;
    mem_io.read_req    = 1'b0;
    if (accept0) begin
      mem_io.addr        = p0_io.addr;
      mem_io.write_data  = p0_io.write_data;
      mem_io.byte_enable = p0_io.byte_enable;
      mem_io.write_req   = p0_io.write_req;
      mem_io.read_req    = p0_io.read_req;
    end else if (accept1) begin
      mem_io.addr        = p1_io.addr;
      mem_io.write_data  = p1_io.write_data;
      mem_io.byte_enable = p1_io.byte_enable;
      mem_io.write_req   = p1_io.write_req;
      mem_io.read_req    = p1_io.read_req;
    end
  end

  assign push    = (accept0 & p0_io.read_req) | (accept1 & p1_io.read_req);
  assign pushTag = accept1;
  assign pop     = mem_io.read_data_valid & notEmpty;
  assign headTag = tag_q[rdPtr_q];

  // Returns arrive in issue order, so the FIFO head always names the owner of this beat.
  assign p0_io.read_data       = mem_io.read_data;
  assign p1_io.read_data       = mem_io.read_data;
  assign p0_io.read_data_valid = pop & (headTag == 1'b0);
  assign p1_io.read_data_valid = pop & (headTag == 1'b1);

  always_comb begin
    lastGrant_d = lastGrant_q;
    count_d     = count_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    if (accept0) begin
      lastGrant_d = 1'b0;
    end else if (accept1) begin
      lastGrant_d = 1'b1;
    end
    if (push) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lastGrant_q <= 1'b1;
      count_q     <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_q[i] <= 1'b0;
      end
    end else begin
      lastGrant_q <= lastGrant_d;
      count_q     <= count_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      if (push) begin
        tag_q[wrPtr_q] <= pushTag;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single reads, contention, full stall, push/pop wrap,
// backpressure and mid-flight reset, with hand-computed expectations.
module tb_mem_arbiter;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  mem_arbiter_if p0If();
  mem_arbiter_if p1If();
  mem_arbiter_if memIf();

  mem_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .p0_io   (p0If.slave),
    .p1_io   (p1If.slave),
    .mem_io  (memIf.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge and outputs are sampled 1ns later, well before the next rising edge.
  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0,
                               input logic r1, input logic w1, input logic [31:0] a1,
                               input logic rdy, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    p0If.read_req        = r0;
    p0If.write_req       = w0;
    p0If.addr            = a0;
    p0If.write_data      = a0 ^ 32'h5555_0000;
    p0If.byte_enable     = 4'hF;
    p1If.read_req        = r1;
    p1If.write_req       = w1;
    p1If.addr            = a1;
    p1If.write_data      = a1 ^ 32'h0000_AAAA;
    p1If.byte_enable     = 4'h3;
    memIf.ready          = rdy;
    memIf.read_data_valid = rv;
    memIf.read_data      = rd;
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic tagQ[$];
  logic popPort;

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;

    // Reset state: a stray return during reset must not reach either port.
    applyStimulus(1, 0, 32'h44, 0, 0, 0, 1, 1, 32'h1234_5678);
    checkOutput("rst_p0_valid", p0If.read_data_valid, 0);
    checkOutput("rst_p1_valid", p1If.read_data_valid, 0);
    checkOutput("rst_count", dut.count_q, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single port read and return.
    applyStimulus(1, 0, 32'h1000_0000, 0, 0, 0, 1, 0, 0);
    checkOutput("single_p0_ready", p0If.ready, 1);
    checkOutput("single_mem_rd", memIf.read_req, 1);
    checkOutput("single_mem_wr", memIf.write_req, 0);
    checkOutput("single_mem_addr", memIf.addr, 32'h1000_0000);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    checkOutput("single_p0_valid", p0If.read_data_valid, 1);
    checkOutput("single_p1_valid", p1If.read_data_valid, 0);
    checkOutput("single_p0_data", p0If.read_data, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("idle_mem_rd", memIf.read_req, 0);

    // Contention: grants alternate starting with port 0, returns follow the same order.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 32'hA0 + i, 1, 0, 32'hB0 + i, 1, 0, 0);
      checkOutput($sformatf("cont_p0_ready%0d", i), p0If.ready, (i % 2 == 0));
      checkOutput($sformatf("cont_p1_ready%0d", i), p1If.ready, (i % 2 == 1));
      checkOutput($sformatf("cont_addr%0d", i), memIf.addr, (i % 2 == 0) ? 32'hA0 + i : 32'hB0 + i);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h100 + i);
      checkOutput($sformatf("cont_p0_valid%0d", i), p0If.read_data_valid, (i % 2 == 0));
      checkOutput($sformatf("cont_p1_valid%0d", i), p1If.read_data_valid, (i % 2 == 1));
    end

    // Full stall: four p1 reads fill the tag FIFO.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 32'h2000 + 4 * i, 1, 0, 0);
      checkOutput($sformatf("fill_p1_ready%0d", i), p1If.ready, 1);
    end
    applyStimulus(0, 0, 0, 1, 0, 32'h2010, 1, 0, 0);
    checkOutput("full_p1_ready", p1If.ready, 0);
    checkOutput("full_mem_rd", memIf.read_req, 0);
    applyStimulus(0, 1, 32'h3000, 1, 0, 32'h2010, 1, 0, 0);
    checkOutput("full_p0_wr_ready", p0If.ready, 1);
    checkOutput("full_p1_ready_b", p1If.ready, 0);
    checkOutput("full_mem_wr", memIf.write_req, 1);
    checkOutput("full_mem_rd_b", memIf.read_req, 0);
    checkOutput("full_mem_addr", memIf.addr, 32'h3000);
    checkOutput("full_mem_wdata", memIf.write_data, 32'h5555_3000);
    applyStimulus(0, 0, 0, 1, 0, 32'h2010, 1, 1, 32'h77);
    checkOutput("full_pop_p1_ready", p1If.ready, 0);
    checkOutput("full_pop_p1_valid", p1If.read_data_valid, 1);
    applyStimulus(0, 0, 0, 1, 0, 32'h2010, 1, 0, 0);
    checkOutput("after_pop_p1_ready", p1If.ready, 1);
    checkOutput("after_pop_mem_rd", memIf.read_req, 1);
    checkOutput("after_pop_be", memIf.byte_enable, 4'h3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h200 + i);
      checkOutput($sformatf("drain_p1_valid%0d", i), p1If.read_data_valid, 1);
      checkOutput($sformatf("drain_p0_valid%0d", i), p0If.read_data_valid, 0);
    end

    // Push and pop together at count 2, long enough to wrap both pointers.
    doReset();
    tagQ.delete();
    applyStimulus(1, 0, 32'h40, 0, 0, 0, 1, 0, 0);
    tagQ.push_back(1'b0);
    applyStimulus(0, 0, 0, 1, 0, 32'h50, 1, 0, 0);
    tagQ.push_back(1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) applyStimulus(1, 0, 32'h60 + k, 0, 0, 0, 1, 1, 32'h300 + k);
      else            applyStimulus(0, 0, 0, 1, 0, 32'h60 + k, 1, 1, 32'h300 + k);
      popPort = tagQ.pop_front();
      tagQ.push_back(k % 2 == 1);
      checkOutput($sformatf("pp_ready%0d", k), (k % 2 == 0) ? p0If.ready : p1If.ready, 1);
      checkOutput($sformatf("pp_p0_valid%0d", k), p0If.read_data_valid, (popPort == 1'b0));
      checkOutput($sformatf("pp_p1_valid%0d", k), p1If.read_data_valid, (popPort == 1'b1));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("pp_count", dut.count_q, 2);

    // Backpressure: stalled cycles leave the grant history alone.
    doReset();
    applyStimulus(0, 1, 32'h70, 0, 0, 0, 1, 0, 0);
    checkOutput("bp_p0_first", p0If.ready, 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 32'h80, 0, 1, 32'h90, 0, 0, 0);
      checkOutput($sformatf("bp_p0_ready%0d", i), p0If.ready, 0);
      checkOutput($sformatf("bp_p1_ready%0d", i), p1If.ready, 0);
      checkOutput($sformatf("bp_mem_wr%0d", i), memIf.write_req, 0);
    end
    applyStimulus(0, 1, 32'h80, 0, 1, 32'h90, 1, 0, 0);
    checkOutput("bp_p1_wins", p1If.ready, 1);
    checkOutput("bp_p0_loses", p0If.ready, 0);
    checkOutput("bp_addr", memIf.addr, 32'h90);

    // Reset mid-flight discards outstanding tags.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 32'hC0 + i, 0, 0, 0, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_count", dut.count_q, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h400 + i);
      checkOutput($sformatf("midrst_p0_valid%0d", i), p0If.read_data_valid, 0);
      checkOutput($sformatf("midrst_p1_valid%0d", i), p1If.read_data_valid, 0);
    end
    applyStimulus(1, 0, 32'hD0, 1, 0, 32'hE0, 1, 0, 0);
    checkOutput("midrst_p0_wins", p0If.ready, 1);
    checkOutput("midrst_p1_loses", p1If.ready, 0);
    checkOutput("midrst_addr", memIf.addr, 32'hD0);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter in front of the memory mapper's single master port.
- Port 0 is the instruction fetch port; port 1 is the data load/store port.
- Round-robin arbitration on the request side.
- A tag FIFO records which port issued each in-flight read, so returning read data goes back to its issuer.
- The downstream mapper returns read data in request order; the arbiter relies on that.

Parameters:
MAX_OUTSTANDING, 4, depth of the in-flight read tag FIFO (max reads issued but not yet returned); power of two, >= 2.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
p0_ready  output  1  port 0 request accepted this cycle if asserted
p0_addr  input  32  port 0 byte address
p0_write_data  input  32  port 0 write data
p0_byte_enable  input  4  port 0 byte enables
p0_write_req  input  1  port 0 write request
p0_read_req  input  1  port 0 read request
p0_read_data  output  32  port 0 read data
p0_read_data_valid  output  1  port 0 read data strobe
p1_ready, p1_addr, p1_write_data, p1_byte_enable, p1_write_req, p1_read_req, p1_read_data, p1_read_data_valid: as port 0, for port 1
mem_ready  input  1  mapper can accept a request this cycle
mem_addr  output  32  to mapper
mem_write_data  output  32  to mapper
mem_byte_enable  output  4  to mapper
mem_write_req  output  1  to mapper
mem_read_req  output  1  to mapper
mem_read_data  input  32  from mapper
mem_read_data_valid  input  1  from mapper, one strobe per accepted read, in order

Behaviour:
- Reset: tag FIFO empty (count=0, rd/wr pointers 0); last_grant=1, so port 0 wins the first contention.
  - pN_read_data_valid=0 while count=0.
  - mem_*_req=0 unless a port requests.
- Requesting: reqN = pN_read_req | pN_write_req.
  - A port must not assert read and write in the same cycle; if it does, both are forwarded and a tag is pushed.
- Winner (combinational):
  - Only one port requesting: that port.
  - Both requesting: the port != last_grant.
  - Neither requesting: no winner.
- Stall condition: full = (count == MAX_OUTSTANDING). A read from the winner is blocked while full, even if a return pops in the same cycle. Writes are never blocked by full.
- pN_ready = mem_ready & (winner==N, or other port not requesting) & !(pN_read_req & full).
  - Purely combinational, no registered latency.
  - Request accepted when pN_ready & reqN.
- mem_addr/write_data/byte_enable/write_req/read_req:
  - Mux from the winner when it is accepted.
  - Otherwise the reqs are 0 and data/addr are 0.
  - mem_*_req is never asserted without a matching pN_ready.
- last_grant updates to N only on an accepted transfer from port N. It holds when idle or stalled.
- Tag push: on an accepted read, write N at wr_ptr, wr_ptr++ (wraps mod MAX_OUTSTANDING), count++.
- Tag pop: on mem_read_data_valid with count!=0, rd_ptr++ (wraps), count--.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Return routing:
  - pN_read_data = mem_read_data on both ports at all times.
  - pN_read_data_valid = mem_read_data_valid & (count!=0) & (tag[rd_ptr]==N).
  - Zero added latency.
- Spurious mem_read_data_valid with count=0: ignored; no valid to either port; state unchanged.
- Reset asserted mid-operation: FIFO cleared immediately and in-flight tags discarded. Returns arriving after reset are spurious and ignored.
- Widths:
  - count is $clog2(MAX_OUTSTANDING+1) bits.
  - Pointers are $clog2(MAX_OUTSTANDING) bits with natural wrap.

Test Plan:
- Single port: p0 reads 0x1000_0000 with mem_ready=1 -> p0_ready=1, mem_read_req=1, mem_addr=0x1000_0000 same cycle; mapper returns 0xDEADBEEF -> p0_read_data_valid=1, p1_read_data_valid=0.
- Contention: both ports read every cycle for 4 cycles, mem_ready=1, returns in order -> grants p0,p1,p0,p1; strobes route to p0,p1,p0,p1.
- Full stall: p1 issues 4 reads with no returns -> 5th read sees p1_ready=0 and mem_read_req=0.
  - p0 write in the same cycle -> accepted.
  - One return -> p1's next read accepted.
- Simultaneous push/pop at count=2: accepted read plus return in one cycle -> count stays 2, correct port strobed; continue 10 cycles to wrap both pointers, routing still correct.
- Backpressure: mem_ready=0 with both requesting -> both readies 0, last_grant unchanged; mem_ready=1 -> port != last_grant wins.
- Reset mid-flight with 3 reads outstanding, then 3 returns -> no pN_read_data_valid; first post-reset contention grants p0.
